// File: rtl/queue_drain.sv
// queue_drain
//   Consumer side of the byte queue. Watches occupancy, issues one-cycle
//   dequeue pulses (at most one outstanding), captures the popped byte after
//   READ_LATENCY cycles and presents it on a valid/ready byte stream. It also
//   counts delivered bytes. When QUEUE_DRAIN_CHECKSUM_EN is defined, it also
//   keeps a running XOR checksum of the delivered bytes.
//
// Parameters
//   READ_LATENCY  cycles from dequeue pulse to popped byte valid (1..7)
//
// Ports
//   clock         in   single clock, posedge
//   reset         in   synchronous, active-high
//   enable_in     in   permits new dequeues (byte in flight always completes)
//   len_in        in   queue occupancy
//   q_data_in     in   queue popped data
//   dequeue_out   out  one-cycle dequeue request
//   data_out      out  byte presented to sink (holds last byte after transfer)
//   valid_out     out  data_out valid
//   ready_in      in   sink accepts; transfer = valid_out && ready_in
//   count_out     out  bytes transferred since reset (wraps)
//   checksum_out  out  XOR of transferred bytes (QUEUE_DRAIN_CHECKSUM_EN only)
module queue_drain #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_in,
    input  logic [3:0]  len_in,
    input  logic [7:0]  q_data_in,
    output logic        dequeue_out,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic [15:0] count_out
`ifdef QUEUE_DRAIN_CHECKSUM_EN
    ,
    output logic [7:0]  checksum_out
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] HOLD = 2'd3;

    localparam logic [2:0] LAT = 3'(READ_LATENCY);

    logic [1:0]  state_q, state_d;
    logic [2:0]  lat_q, lat_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic [15:0] count_q, count_d;
    logic        xfer;
    logic        can_pop;

    // valid_q is only ever set in HOLD, so this is the sink handshake proper.
    assign xfer    = valid_q && ready_in;
    // Occupancy is only consulted from IDLE and on the HOLD transfer edge;
    // during POP/WAIT the queue's count is still settling.
    assign can_pop = enable_in && (len_in != 4'd0);

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (can_pop) state_d = POP;
            end
            POP: begin
                lat_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                // Last wait cycle: the popped byte is on q_data_in now.
                if (lat_q == 3'd1) begin
                    data_d  = q_data_in;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    count_d = count_q + 16'd1;
                    // Back-to-back pop without an IDLE bubble.
                    state_d = can_pop ? POP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            lat_q   <= 3'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign dequeue_out = (state_q == POP);
    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign count_out   = count_q;

`ifdef QUEUE_DRAIN_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (xfer) csum_d = csum_q ^ data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) csum_q <= 8'h00;
        else       csum_q <= csum_d;
    end

    assign checksum_out = csum_q;
`endif

endmodule

// File: tb/tb_queue_drain.sv
// Testbench for queue_drain: directed steps plus a randomized phase, all
// checked every cycle against a transaction-level reference model.
module tb_queue_drain;

    localparam int RL = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_in = 1'b0;
    logic [3:0]  len_in = 4'd0;
    logic [7:0]  q_data_in = 8'h00;
    logic        ready_in = 1'b0;
    logic        dequeue_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic [15:0] count_out;
`ifdef QUEUE_DRAIN_CHECKSUM_EN
    logic [7:0]  checksum_out;
`endif

    always #5 clock = ~clock;

    queue_drain #(.READ_LATENCY(RL)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable_in   (enable_in),
        .len_in      (len_in),
        .q_data_in   (q_data_in),
        .dequeue_out (dequeue_out),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .ready_in    (ready_in),
        .count_out   (count_out)
`ifdef QUEUE_DRAIN_CHECKSUM_EN
        ,
        .checksum_out(checksum_out)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a byte is either in flight (popped at m_pop_cyc,
    // arriving RL cycles later) or held for the sink, or neither.
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_hold = 0;
    int          m_pop_cyc = -100;
    logic [7:0]  m_data = 8'h00;
    logic [15:0] m_count = 16'h0000;
    logic [7:0]  m_csum = 8'h00;

    // Queue emulation for the streaming step.
    bit          q_emul = 0;
    logic [7:0]  stream_b [4] = '{8'h01, 8'h02, 8'h04, 8'h08};
    int          sidx = 0;
    int          deq_cyc[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_busy  = 0;
            m_hold  = 0;
            m_data  = 8'h00;
            m_count = 16'h0000;
            m_csum  = 8'h00;
        end else if (m_hold) begin
            if (ready_in) begin
                m_count = m_count + 16'd1;
                m_csum  = m_csum ^ m_data;
                m_hold  = 0;
                if (enable_in && len_in != 4'd0) begin
                    m_busy    = 1;
                    m_pop_cyc = cyc + 1;
                end
            end
        end else if (m_busy) begin
            if (cyc == m_pop_cyc + RL) begin
                m_data = q_data_in;
                m_hold = 1;
                m_busy = 0;
            end
        end else if (enable_in && len_in != 4'd0) begin
            m_busy    = 1;
            m_pop_cyc = cyc + 1;
        end
    endtask

    task automatic check_outputs();
        logic exp_deq;
        exp_deq = m_busy && (m_pop_cyc == cyc);
        chk("dequeue_out", {15'd0, dequeue_out}, {15'd0, exp_deq});
        chk("valid_out", {15'd0, valid_out}, {15'd0, m_hold});
        chk("data_out", {8'd0, data_out}, {8'd0, m_data});
        chk("count_out", count_out, m_count);
`ifdef QUEUE_DRAIN_CHECKSUM_EN
        chk("checksum_out", {8'd0, checksum_out}, {8'd0, m_csum});
`endif
    endtask

    task automatic tick();
        logic deq_seen;
        deq_seen = dequeue_out;
        @(posedge clock);
        model_edge();
        cyc++;
        #1;
        if (q_emul && deq_seen) begin
            if (len_in != 4'd0) len_in = len_in - 4'd1;
            if (sidx < 4) q_data_in = stream_b[sidx];
            sidx++;
        end
        if (dequeue_out === 1'b1) deq_cyc.push_back(cyc);
        check_outputs();
    endtask

    task automatic wait_deq(input int lim);
        for (int i = 0; i < lim && dequeue_out !== 1'b1; i++) tick();
        chk("wait_dequeue", {15'd0, dequeue_out}, 16'd1);
    endtask

    initial begin
        logic [15:0] cnt0;

        // Reset held 3 cycles while the queue reports data
        reset = 1'b1; len_in = 4'd5; enable_in = 1'b1; ready_in = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (12) tick();
        len_in = 4'd0;
        repeat (12) tick();

        // Single byte
        q_data_in = 8'hA5; len_in = 4'd1; ready_in = 1'b1;
        cnt0 = count_out;
        wait_deq(10);
        len_in = 4'd0;
        repeat (RL + 2) tick();
        chk("single_data", {8'd0, data_out}, 16'h00A5);
        chk("single_count", count_out, cnt0 + 16'd1);

        // Backpressure
        ready_in = 1'b0; q_data_in = 8'h3C; len_in = 4'd1;
        for (int i = 0; i < 20 && valid_out !== 1'b1; i++) tick();
        cnt0 = count_out;
        deq_cyc.delete();
        repeat (10) tick();
        chk("bp_hold_data", {8'd0, data_out}, 16'h003C);
        chk("bp_no_pop", 16'(deq_cyc.size()), 16'd0);
        len_in = 4'd0; ready_in = 1'b1;
        tick();
        tick();
        chk("bp_count", count_out, cnt0 + 16'd1);
        repeat (4) tick();

        // Streaming four bytes from a reset state
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        deq_cyc.delete();
        sidx = 0; q_emul = 1; len_in = 4'd4; enable_in = 1'b1; ready_in = 1'b1;
        repeat (30) tick();
        q_emul = 0;
        chk("stream_pops", 16'(deq_cyc.size()), 16'd4);
        for (int i = 1; i < deq_cyc.size(); i++)
            chk("stream_spacing", 16'(deq_cyc[i] - deq_cyc[i-1]), 16'(RL + 2));
        chk("stream_count", count_out, 16'd4);
`ifdef QUEUE_DRAIN_CHECKSUM_EN
        chk("stream_csum", {8'd0, checksum_out}, 16'h000F);
`endif

        // enable_in dropped during WAIT
        len_in = 4'd3; enable_in = 1'b1; q_data_in = 8'h77;
        cnt0 = count_out;
        deq_cyc.delete();
        wait_deq(10);
        tick();
        enable_in = 1'b0;
        repeat (15) tick();
        chk("en_drop_pops", 16'(deq_cyc.size()), 16'd1);
        chk("en_drop_count", count_out, cnt0 + 16'd1);
        chk("en_drop_data", {8'd0, data_out}, 16'h0077);

        // Reset asserted while a byte is in flight
        enable_in = 1'b1; len_in = 4'd2; q_data_in = 8'h99;
        wait_deq(10);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; len_in = 4'd0;
        repeat (8) tick();
        chk("rst_wait_valid", {15'd0, valid_out}, 16'd0);
        chk("rst_wait_count", count_out, 16'd0);

        // Counter wrap: preload the counter to its last value
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        m_count = 16'hFFFF;
        chk("wrap_preload", count_out, 16'hFFFF);
        len_in = 4'd1; q_data_in = 8'h5A; ready_in = 1'b1;
        wait_deq(10);
        len_in = 4'd0;
        repeat (RL + 3) tick();
        chk("wrap_count", count_out, 16'h0000);

        // Randomized phase
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            enable_in = ($urandom_range(0, 99) < 85);
            ready_in  = ($urandom_range(0, 99) < 70);
            len_in    = ($urandom_range(0, 99) < 30) ? 4'd0 : 4'($urandom_range(1, 15));
            q_data_in = 8'($urandom);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
